// File: rtl/display_share_if.sv
// Display-sharing bus: three requesters (err, res, opd) and the registered
// grant/display outputs of display_share_ctrl.
interface display_share_if;
  logic        req_err;
  logic [15:0] data_err;
  logic        req_res;
  logic [15:0] data_res;
  logic        req_opd;
  logic [15:0] data_opd;
  logic        gnt_err;
  logic        gnt_res;
  logic        gnt_opd;
  logic [15:0] disp_num;
  logic [1:0]  disp_src;
  logic        disp_blank;

  // requester side
  modport master (
    output req_err, data_err, req_res, data_res, req_opd, data_opd,
    input  gnt_err, gnt_res, gnt_opd, disp_num, disp_src, disp_blank
  );

  // arbiter side
  modport slave (
    input  req_err, data_err, req_res, data_res, req_opd, data_opd,
    output gnt_err, gnt_res, gnt_opd, disp_num, disp_src, disp_blank
  );
endinterface

// File: rtl/display_share_ctrl.sv
// Arbitrates one 4-digit seven-segment display among error, result and
// operand-entry sources (fixed priority err > res > opd) with a minimum hold
// time and an IDLE -> OWN -> LINGER -> IDLE lifecycle.
// Optional feature macro: DISPLAY_SHARE_BLINK_EN (blinks the display while
// the error source owns it).
module display_share_ctrl #(
  parameter int HOLD_CYCLES  = 50000000,
  parameter int CNT_W        = 26,
  parameter int BLINK_CYCLES = 12500000
) (
  input logic             clk,
  input logic             clr,
  display_share_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, OWN, LINGER} state_t;

  state_t            state, state_nx;
  logic [2:0]        gnt_q, gnt_nx;
  logic [15:0]       num_q, num_nx;
  logic [1:0]        src_q, src_nx;
  logic              blank_q, blank_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;

  logic [3:0]        pend;
  logic [3:0][15:0]  data;
  logic [1:0]        hp;
  logic              any_req, hold_done, grant;

  // index 3 is the "no source" slot so src/hp can index directly
  assign pend = {1'b0, bus.req_opd, bus.req_res, bus.req_err};
  assign data = {16'h0000, bus.data_opd, bus.data_res, bus.data_err};
  assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  // highest-priority pending requester, 3 when none
  always_comb begin
    hp = 2'd3;
    if (bus.req_opd) hp = 2'd2;
    if (bus.req_res) hp = 2'd1;
    if (bus.req_err) hp = 2'd0;
  end
  assign any_req = (hp != 2'd3);

`ifdef DISPLAY_SHARE_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] bcnt_q, bcnt_nx;
`else
  // blink half-period has no effect without the blink feature
  wire unused_blink = (BLINK_CYCLES != 0);
`endif

  // next-state, grant and display selection
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    num_nx   = num_q;
    src_nx   = src_q;
    blank_nx = blank_q;
    cnt_nx   = cnt_q;
    grant    = 1'b0;
`ifdef DISPLAY_SHARE_BLINK_EN
    bcnt_nx  = bcnt_q;
`endif
    case (state)
      IDLE: begin
        if (any_req) grant = 1'b1;
      end
      OWN: begin
        cnt_nx = hold_done ? cnt_q : cnt_q + 1'b1;
        if (!pend[src_q]) begin
          if (any_req) grant = 1'b1;
          else begin
            // owner released: keep the last value up while the hold runs out
            state_nx = LINGER;
            gnt_nx   = 3'b000;
            blank_nx = 1'b0;
          end
        end else if (hp < src_q && hold_done) begin
          grant = 1'b1;
        end else begin
          num_nx = data[src_q];
`ifdef DISPLAY_SHARE_BLINK_EN
          if (src_q == 2'd0) begin
            if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
              bcnt_nx  = '0;
              blank_nx = ~blank_q;
            end else begin
              bcnt_nx = bcnt_q + 1'b1;
            end
          end
`endif
        end
      end
      LINGER: begin
        cnt_nx = hold_done ? cnt_q : cnt_q + 1'b1;
        if (any_req) grant = 1'b1;
        else if (hold_done) begin
          state_nx = IDLE;
          num_nx   = 16'h0000;
          src_nx   = 2'd3;
          blank_nx = 1'b1;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (grant) begin
      state_nx = OWN;
      gnt_nx   = 3'b001 << hp;
      num_nx   = data[hp];
      src_nx   = hp;
      blank_nx = 1'b0;
      cnt_nx   = '0;
`ifdef DISPLAY_SHARE_BLINK_EN
      bcnt_nx  = '0;
`endif
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      gnt_q   <= 3'b000;
      num_q   <= 16'h0000;
      src_q   <= 2'd3;
      blank_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      gnt_q   <= gnt_nx;
      num_q   <= num_nx;
      src_q   <= src_nx;
      blank_q <= blank_nx;
      cnt_q   <= cnt_nx;
    end
  end

`ifdef DISPLAY_SHARE_BLINK_EN
  // blink phase counter, restarted on every grant
  always_ff @(posedge clk or posedge clr) begin
    if (clr) bcnt_q <= '0;
    else     bcnt_q <= bcnt_nx;
  end
`endif

  assign bus.gnt_err    = gnt_q[0];
  assign bus.gnt_res    = gnt_q[1];
  assign bus.gnt_opd    = gnt_q[2];
  assign bus.disp_num   = num_q;
  assign bus.disp_src   = src_q;
  assign bus.disp_blank = blank_q;
endmodule
